// File: rtl/ngx_http_parse_time_mul_pkg.sv
// Shared constants and helpers for the ngx_http_parse_time pipelined multiplier.
// Product width function, saturation bounds and the supported stage-count ceiling.
package ngx_http_parse_time_mul_pkg;

  localparam int MUL_MAX_NUM_STAGE = 6;

  // One extra bit covers the zero-extension of an unsigned operand.
  function automatic int prod_width(input int wa, input int wb);
    return wa + wb + 1;
  endfunction

  function automatic logic [63:0] sat_max(input int w, input bit is_signed);
    logic [63:0] ones;
    ones = '1;
    return is_signed ? (ones >> (65 - w)) : (ones >> (64 - w));
  endfunction

  function automatic logic [63:0] sat_min(input int w, input bit is_signed);
    return is_signed ? (64'd1 << (w - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/ngx_http_parse_time_mul_pipe_dsp.sv
// Combinational signed multiply on pre-extended operands; the only DSP inference point.
module ngx_http_parse_time_mul_pipe_dsp
  import ngx_http_parse_time_mul_pkg::*;
#(
  parameter int WA = 22,
  parameter int WB = 19
) (
  input  logic [WA-1:0]                     a_i,
  input  logic [WB-1:0]                     b_i,
  output logic [prod_width(WA-1, WB-1)-1:0] p_o
);

  localparam int P = prod_width(WA - 1, WB - 1);

  logic signed [P-1:0] a_ext;
  logic signed [P-1:0] b_ext;

  assign a_ext = P'(signed'(a_i));
  assign b_ext = P'(signed'(b_i));
  assign p_o   = a_ext * b_ext;

endmodule

// File: rtl/ngx_http_parse_time_mul_pipe.sv
// Pipelined multiplier with per-operand signedness, tag sideband and valid/ready stall.
// Optional clamp-on-overflow of the final result: define NGX_HTTP_PARSE_TIME_MUL_SAT_EN.
module ngx_http_parse_time_mul_pipe
  import ngx_http_parse_time_mul_pkg::*;
#(
  parameter int din0_WIDTH = 21,
  parameter int din1_WIDTH = 18,
  parameter int dout_WIDTH = 40,
  parameter int A_SIGNED   = 0,
  parameter int B_SIGNED   = 1,
  parameter int NUM_STAGE  = 2,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  ovf
);

  localparam int P  = prod_width(din0_WIDTH, din1_WIDTH);
  localparam bit RS = (A_SIGNED != 0) || (B_SIGNED != 0);
  // Out-of-range stage requests are clamped to the supported range.
  localparam int NS = (NUM_STAGE < 1) ? 1 :
                      ((NUM_STAGE > MUL_MAX_NUM_STAGE) ? MUL_MAX_NUM_STAGE : NUM_STAGE);

  // Handshake: a transfer happens on valid & ready at the rising edge. The whole
  // pipeline advances together when the output slot is empty or being drained, so
  // in_ready never looks at in_valid and a full pipe moves one result per cycle.
  logic                  adv;
  logic [NS-1:0]         vld_q;
  logic [TAG_WIDTH-1:0]  tag_q [NS];
  logic [din0_WIDTH:0]   a_x;
  logic [din1_WIDTH:0]   b_x;
  logic [P-1:0]          mul_p;
  logic [P-1:0]          fin_p;
  logic [dout_WIDTH-1:0] dout_d, dout_q;
  logic                  ovf_d, ovf_q;

  assign adv       = !vld_q[NS-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[NS-1];
  assign dout      = dout_q;
  assign out_tag   = tag_q[NS-1];
  assign ovf       = ovf_q;

  assign a_x = {(A_SIGNED != 0) && din0[din0_WIDTH-1], din0};
  assign b_x = {(B_SIGNED != 0) && din1[din1_WIDTH-1], din1};

  generate
    if (NS == 1) begin : g_s1
      ngx_http_parse_time_mul_pipe_dsp #(.WA(din0_WIDTH + 1), .WB(din1_WIDTH + 1)) u_dsp (
        .a_i(a_x), .b_i(b_x), .p_o(mul_p)
      );
      assign fin_p = mul_p;
    end else begin : g_sn
      logic [din0_WIDTH:0] a_q;
      logic [din1_WIDTH:0] b_q;

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_x;
          b_q <= b_x;
        end
      end

      ngx_http_parse_time_mul_pipe_dsp #(.WA(din0_WIDTH + 1), .WB(din1_WIDTH + 1)) u_dsp (
        .a_i(a_q), .b_i(b_q), .p_o(mul_p)
      );

      if (NS == 2) begin : g_nomid
        assign fin_p = mul_p;
      end else begin : g_mid
        logic [P-1:0] prod_q [NS-2];

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
          if (!ap_rst_n) begin
            for (int i = 0; i < NS - 2; i++) prod_q[i] <= '0;
          end else if (adv) begin
            prod_q[0] <= mul_p;
            for (int i = 1; i < NS - 2; i++) prod_q[i] <= prod_q[i-1];
          end
        end

        assign fin_p = prod_q[NS-3];
      end
    end

    if (dout_WIDTH >= P) begin : g_wide
      if (RS) begin : g_sext
        assign dout_d = dout_WIDTH'(signed'(fin_p));
      end else begin : g_zext
        assign dout_d = dout_WIDTH'(fin_p);
      end
      assign ovf_d = 1'b0;
    end else begin : g_narrow
`ifdef NGX_HTTP_PARSE_TIME_MUL_SAT_EN
      localparam logic [dout_WIDTH-1:0] SAT_HI = dout_WIDTH'(sat_max(dout_WIDTH, RS));
      localparam logic [dout_WIDTH-1:0] SAT_LO = dout_WIDTH'(sat_min(dout_WIDTH, RS));
      logic fits;
      // A signed result fits when every bit above the dout sign bit repeats it.
      if (RS) begin : g_sfit
        assign fits = (&fin_p[P-1:dout_WIDTH-1]) || !(|fin_p[P-1:dout_WIDTH-1]);
      end else begin : g_ufit
        assign fits = !(|fin_p[P-1:dout_WIDTH]);
      end
      assign dout_d = fits ? fin_p[dout_WIDTH-1:0] : (fin_p[P-1] ? SAT_LO : SAT_HI);
      assign ovf_d  = !fits;
`else
      logic unused_hi;
      assign unused_hi = ^fin_p[P-1:dout_WIDTH];
      assign dout_d    = fin_p[dout_WIDTH-1:0];
      assign ovf_d     = 1'b0;
`endif
    end
  endgenerate

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q  <= '0;
      for (int i = 0; i < NS; i++) tag_q[i] <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      tag_q[0] <= in_tag;
      for (int i = 1; i < NS; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ngx_http_parse_time_mul_pipe.sv
// Directed bench for ngx_http_parse_time_mul_pipe across five parameter sets.
// Expected saturation results follow NGX_HTTP_PARSE_TIME_MUL_SAT_EN when it is defined.
module tb_ngx_http_parse_time_mul_pipe;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0] exp_q[$];
  logic [7:0]  exp_tag_q[$];
  logic        exp_ovf_q[$];

`ifdef NGX_HTTP_PARSE_TIME_MUL_SAT_EN
  localparam logic [15:0] S_EXP_POS = 16'h7FFF;
  localparam logic [15:0] S_EXP_NEG = 16'h8000;
  localparam logic        S_EXP_OVF = 1'b1;
`else
  localparam logic [15:0] S_EXP_POS = 16'hEA60;
  localparam logic [15:0] S_EXP_NEG = 16'h15A0;
  localparam logic        S_EXP_OVF = 1'b0;
`endif

  // u_a: default configuration
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
  logic [20:0] a_din0; logic [17:0] a_din1; logic [3:0] a_tag, a_out_tag; logic [39:0] a_dout;
  // u_s: 16x16 signed, 16-bit result
  logic s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_ovf;
  logic [15:0] s_din0, s_din1, s_dout; logic [3:0] s_tag, s_out_tag;
  // u_p: three stages
  logic p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_ovf;
  logic [20:0] p_din0; logic [17:0] p_din1; logic [3:0] p_tag, p_out_tag; logic [39:0] p_dout;
  // u_n: single stage unsigned 8x8
  logic n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_ovf;
  logic [7:0] n_din0, n_din1; logic [15:0] n_dout; logic [3:0] n_tag, n_out_tag;
  // u_m: 18x18 signed, 37-bit result
  logic m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_ovf;
  logic [17:0] m_din0, m_din1; logic [36:0] m_dout; logic [3:0] m_tag, m_out_tag;

  ngx_http_parse_time_mul_pipe u_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .din0(a_din0), .din1(a_din1), .in_tag(a_tag), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .dout(a_dout), .out_tag(a_out_tag), .ovf(a_ovf));

  ngx_http_parse_time_mul_pipe #(.din0_WIDTH(16), .din1_WIDTH(16), .dout_WIDTH(16),
    .A_SIGNED(1), .B_SIGNED(1), .NUM_STAGE(2), .TAG_WIDTH(4)) u_s (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .din0(s_din0), .din1(s_din1), .in_tag(s_tag), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .dout(s_dout), .out_tag(s_out_tag), .ovf(s_ovf));

  ngx_http_parse_time_mul_pipe #(.NUM_STAGE(3)) u_p (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .din0(p_din0), .din1(p_din1), .in_tag(p_tag), .out_valid(p_out_valid),
    .out_ready(p_out_ready), .dout(p_dout), .out_tag(p_out_tag), .ovf(p_ovf));

  ngx_http_parse_time_mul_pipe #(.din0_WIDTH(8), .din1_WIDTH(8), .dout_WIDTH(16),
    .A_SIGNED(0), .B_SIGNED(0), .NUM_STAGE(1), .TAG_WIDTH(4)) u_n (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .din0(n_din0), .din1(n_din1), .in_tag(n_tag), .out_valid(n_out_valid),
    .out_ready(n_out_ready), .dout(n_dout), .out_tag(n_out_tag), .ovf(n_ovf));

  ngx_http_parse_time_mul_pipe #(.din0_WIDTH(18), .din1_WIDTH(18), .dout_WIDTH(37),
    .A_SIGNED(1), .B_SIGNED(1), .NUM_STAGE(2), .TAG_WIDTH(4)) u_m (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .din0(m_din0), .din1(m_din1), .in_tag(m_tag), .out_valid(m_out_valid),
    .out_ready(m_out_ready), .dout(m_dout), .out_tag(m_out_tag), .ovf(m_ovf));

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic push_exp(input logic [47:0] d, input logic [7:0] t, input logic o);
    exp_q.push_back(d);
    exp_tag_q.push_back(t);
    exp_ovf_q.push_back(o);
  endtask

  task automatic drop_exp();
    void'(exp_q.pop_front());
    void'(exp_tag_q.pop_front());
    void'(exp_ovf_q.pop_front());
  endtask

  task automatic test_reset();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    n_checks++; if (a_dout !== 40'd0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", a_dout); end
    n_checks++; if (a_out_tag !== 4'd0 || a_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_tag_ovf: got %h/%b want 0/0", a_out_tag, a_ovf); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    n_checks++; if (p_out_valid !== 1'b0 || n_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_other_valid: got %b/%b want 0/0", p_out_valid, n_out_valid); end
  endtask

  task automatic test_back_to_back();
    a_out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c == 0) begin
        a_in_valid = 1'b1; a_din0 = 21'd2097151; a_din1 = 18'h20000; a_tag = 4'd5;
      end else if (c < 8) begin
        a_in_valid = 1'b1; a_din0 = 21'(c + 1); a_din1 = 18'(-(c + 1)); a_tag = 4'(c);
      end else begin
        a_in_valid = 1'b0;
      end
      #1;
      n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c=%0d: got %b want 1", c, a_in_ready); end
      n_checks++; if (a_out_valid !== (c >= 2 && c <= 9)) begin n_fail++; $display("FAIL b2b_latency c=%0d: got out_valid=%b", c, a_out_valid); end
      if (a_out_valid && a_out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_unexpected: got dout=%h", a_dout); end
        else begin
          if (a_dout !== exp_q[0][39:0] || a_out_tag !== exp_tag_q[0][3:0] || a_ovf !== exp_ovf_q[0]) begin
            n_fail++; $display("FAIL b2b_result: got %h/%h/%b want %h/%h/%b", a_dout, a_out_tag, a_ovf, exp_q[0][39:0], exp_tag_q[0][3:0], exp_ovf_q[0]);
          end
          drop_exp();
        end
      end
      if (a_in_valid && a_in_ready) begin
        if (c == 0) push_exp(48'(40'hC000020000), 8'd5, 1'b0);
        else push_exp(48'(40'(-(c + 1) * (c + 1))), 8'(c), 1'b0);
      end
      tick();
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: got %0d left want 0", exp_q.size()); end
    exp_q.delete(); exp_tag_q.delete(); exp_ovf_q.delete();
  endtask

  task automatic test_saturation();
    s_out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      s_in_valid = (c < 3);
      case (c)
        0: begin s_din0 = 16'd300;   s_din1 = 16'd200;   s_tag = 4'd1; end
        1: begin s_din0 = 16'hFED4;  s_din1 = 16'd200;   s_tag = 4'd2; end
        default: begin s_din0 = 16'd100; s_din1 = 16'hFF38; s_tag = 4'd3; end
      endcase
      #1;
      if (s_out_valid && s_out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL sat_unexpected: got dout=%h", s_dout); end
        else begin
          if (s_dout !== exp_q[0][15:0] || s_out_tag !== exp_tag_q[0][3:0] || s_ovf !== exp_ovf_q[0]) begin
            n_fail++; $display("FAIL sat_result: got %h/%h/%b want %h/%h/%b", s_dout, s_out_tag, s_ovf, exp_q[0][15:0], exp_tag_q[0][3:0], exp_ovf_q[0]);
          end
          drop_exp();
        end
      end
      if (s_in_valid && s_in_ready) begin
        case (c)
          0: push_exp(48'(S_EXP_POS), 8'd1, S_EXP_OVF);
          1: push_exp(48'(S_EXP_NEG), 8'd2, S_EXP_OVF);
          default: push_exp(48'(16'hB1E0), 8'd3, 1'b0);
        endcase
      end
      tick();
    end
    s_in_valid = 1'b0;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sat_drain: got %0d left want 0", exp_q.size()); end
    exp_q.delete(); exp_tag_q.delete(); exp_ovf_q.delete();
  endtask

  task automatic test_stall();
    int idx = 0;
    int acc = 0;
    int outs = 0;
    bit held = 1'b0;
    logic [39:0] held_dout;
    logic [3:0]  held_tag;
    p_out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      p_in_valid = 1'b1; p_din0 = 21'(10 * (idx + 1)); p_din1 = 18'(3 - idx); p_tag = 4'(idx + 1);
      #1;
      if (p_out_valid) begin
        if (!held) begin
          held = 1'b1; held_dout = p_dout; held_tag = p_out_tag;
          n_checks++; if (p_dout !== exp_q[0][39:0]) begin n_fail++; $display("FAIL stall_first: got %h want %h", p_dout, exp_q[0][39:0]); end
        end else begin
          n_checks++; if (p_dout !== held_dout || p_out_tag !== held_tag) begin n_fail++; $display("FAIL stall_hold c=%0d: got %h/%h want %h/%h", c, p_dout, p_out_tag, held_dout, held_tag); end
        end
      end
      if (p_in_valid && p_in_ready) begin
        push_exp(48'(40'(10 * (idx + 1) * (3 - idx))), 8'(idx + 1), 1'b0);
        idx++; acc++;
      end
      tick();
    end
    #1;
    n_checks++; if (acc != 3) begin n_fail++; $display("FAIL stall_accepted: got %0d want 3", acc); end
    n_checks++; if (p_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", p_in_ready); end
    p_out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      p_in_valid = (idx < 5); p_din0 = 21'(10 * (idx + 1)); p_din1 = 18'(3 - idx); p_tag = 4'(idx + 1);
      #1;
      if (p_out_valid && p_out_ready) begin
        n_checks++; outs++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL stall_unexpected: got dout=%h", p_dout); end
        else begin
          if (p_dout !== exp_q[0][39:0] || p_out_tag !== exp_tag_q[0][3:0] || p_ovf !== exp_ovf_q[0]) begin
            n_fail++; $display("FAIL stall_result: got %h/%h/%b want %h/%h/%b", p_dout, p_out_tag, p_ovf, exp_q[0][39:0], exp_tag_q[0][3:0], exp_ovf_q[0]);
          end
          drop_exp();
        end
      end
      if (p_in_valid && p_in_ready) begin
        push_exp(48'(40'(10 * (idx + 1) * (3 - idx))), 8'(idx + 1), 1'b0);
        idx++;
      end
      tick();
    end
    n_checks++; if (outs != 5 || exp_q.size() != 0) begin n_fail++; $display("FAIL stall_count: got %0d outputs, %0d left want 5, 0", outs, exp_q.size()); end
    exp_q.delete(); exp_tag_q.delete(); exp_ovf_q.delete();
  endtask

  task automatic test_single_stage();
    int sent = 0;
    bit prev_stall = 1'b0;
    logic [15:0] prev_dout;
    logic [3:0]  prev_tag;
    n_out_ready = 1'b1;
    n_in_valid = 1'b1; n_din0 = 8'd255; n_din1 = 8'd255; n_tag = 4'd9;
    #1;
    tick();
    n_in_valid = 1'b0;
    #1;
    n_checks++; if (n_out_valid !== 1'b1 || n_dout !== 16'd65025 || n_out_tag !== 4'd9) begin n_fail++; $display("FAIL single_255: got %b/%0d/%h want 1/65025/9", n_out_valid, n_dout, n_out_tag); end
    tick();
    for (int c = 0; c < 4000 && (sent < 1000 || exp_q.size() != 0); c++) begin
      n_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      n_din0      = 8'($urandom_range(0, 255));
      n_din1      = 8'($urandom_range(0, 255));
      n_tag       = 4'($urandom_range(0, 15));
      n_out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        n_checks++; if (n_out_valid !== 1'b1 || n_dout !== prev_dout || n_out_tag !== prev_tag) begin n_fail++; $display("FAIL rand_hold: got %h/%h want %h/%h", n_dout, n_out_tag, prev_dout, prev_tag); end
      end
      if (n_out_valid && n_out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_unexpected: got dout=%h", n_dout); end
        else begin
          if (n_dout !== exp_q[0][15:0] || n_out_tag !== exp_tag_q[0][3:0] || n_ovf !== exp_ovf_q[0]) begin
            n_fail++; $display("FAIL rand_result: got %h/%h/%b want %h/%h/%b", n_dout, n_out_tag, n_ovf, exp_q[0][15:0], exp_tag_q[0][3:0], exp_ovf_q[0]);
          end
          drop_exp();
        end
      end
      prev_stall = n_out_valid && !n_out_ready;
      prev_dout  = n_dout;
      prev_tag   = n_out_tag;
      if (n_in_valid && n_in_ready) begin
        push_exp(48'(16'(n_din0) * 16'(n_din1)), 8'(n_tag), 1'b0);
        sent++;
      end
      tick();
    end
    n_in_valid = 1'b0; n_out_ready = 1'b1;
    n_checks++; if (sent != 1000 || exp_q.size() != 0) begin n_fail++; $display("FAIL rand_timeout: got sent=%0d left=%0d want 1000/0", sent, exp_q.size()); end
    exp_q.delete(); exp_tag_q.delete(); exp_ovf_q.delete();
  endtask

  task automatic test_min_min();
    m_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      m_in_valid = (c < 2);
      m_din0 = (c == 0) ? 18'h20000 : 18'h1FFFF; m_din1 = 18'h20000; m_tag = 4'(c + 1);
      #1;
      if (m_out_valid && m_out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL minmin_unexpected: got dout=%h", m_dout); end
        else begin
          if (m_dout !== exp_q[0][36:0] || m_out_tag !== exp_tag_q[0][3:0] || m_ovf !== exp_ovf_q[0]) begin
            n_fail++; $display("FAIL minmin_result: got %h/%h/%b want %h/%h/%b", m_dout, m_out_tag, m_ovf, exp_q[0][36:0], exp_tag_q[0][3:0], exp_ovf_q[0]);
          end
          drop_exp();
        end
      end
      if (m_in_valid && m_in_ready) begin
        if (c == 0) push_exp(48'(37'd17179869184), 8'd1, 1'b0);
        else push_exp(48'(37'h1C00020000), 8'd2, 1'b0);
      end
      tick();
    end
    m_in_valid = 1'b0;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL minmin_drain: got %0d left want 0", exp_q.size()); end
    exp_q.delete(); exp_tag_q.delete(); exp_ovf_q.delete();
  endtask

  task automatic test_async_reset();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_din0 = 21'd7; a_din1 = 18'd3; a_tag = 4'd1;
    tick();
    a_din0 = 21'd9; a_tag = 4'd2;
    tick();
    a_in_valid = 1'b0;
    #1;
    n_checks++; if (a_out_valid !== 1'b1 || a_dout !== 40'd21) begin n_fail++; $display("FAIL arst_pre: got %b/%0d want 1/21", a_out_valid, a_dout); end
    #1 ap_rst_n = 1'b0;
    #1;
    n_checks++; if (a_out_valid !== 1'b0 || a_dout !== 40'd0) begin n_fail++; $display("FAIL arst_immediate: got %b/%h want 0/0", a_out_valid, a_dout); end
    n_checks++; if (a_out_tag !== 4'd0 || a_ovf !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_side: got %h/%b/%b want 0/0/1", a_out_tag, a_ovf, a_in_ready); end
    tick();
    tick();
    ap_rst_n = 1'b1;
    a_out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_stale c=%0d: got %b/%b want 0/1", c, a_out_valid, a_in_ready); end
      tick();
    end
  endtask

  initial begin
    a_in_valid = 0; a_out_ready = 1; a_din0 = '0; a_din1 = '0; a_tag = '0;
    s_in_valid = 0; s_out_ready = 1; s_din0 = '0; s_din1 = '0; s_tag = '0;
    p_in_valid = 0; p_out_ready = 1; p_din0 = '0; p_din1 = '0; p_tag = '0;
    n_in_valid = 0; n_out_ready = 1; n_din0 = '0; n_din1 = '0; n_tag = '0;
    m_in_valid = 0; m_out_ready = 1; m_din0 = '0; m_din1 = '0; m_tag = '0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    #1;
    test_reset();
    test_back_to_back();
    test_saturation();
    test_stall();
    test_single_stage();
    test_min_min();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
